cbrt_calc: RTL and testbench
============================

# cbrt_calc

Sequential 8-bit unsigned integer cube-root unit: on a `start` pulse it latches an operand, computes floor(∛x) with a multi-cycle state machine, and presents a 3-bit root while dropping `busy`. All additions and subtractions go through one shared, purely combinational 16-bit adder instance (`sum`) inside the block. The unit is a small arithmetic helper for datapaths that tolerate tens of cycles of latency and need no multiplier.

## Interface
- No parameters. Widths are fixed: operand 8 bits, root 3 bits, adder 16 bits.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: request, sampled on a rising edge while idle.
- `x_i` input 8: unsigned operand, sampled in the same cycle as `start`.
- `result` output 3: floor(∛x), registered.
- `busy` output 1: high while a computation is in progress.
- Internal adder `sum`: inputs `a`[15:0] and `b`[15:0], output `result`[15:0] = (a+b) mod 2^16. Combinational, no carry-out.

## Operation
- Algorithm: bit-serial cube root over shifts s = 6, 3, 0, with working remainder X (16 bits, starts at x), root y (starts at 0), and one group per shift:
  - y ← 2y
  - t ← y·(y+1), formed by adding y into an accumulator (y+1) times through the adder
  - b ← 3t + 1, formed as t+t, then +t, then +1
  - if X ≥ (b << s): X ← X − (b << s) and y ← y+1
- Subtraction: X + (~B) through the adder, then +1 through the adder.
- Shifts, comparisons and inversions are plain logic. Every other add uses the `sum` instance, one add per cycle.
- FSM states:
  - IDLE
  - INIT: latch x_i, clear y, set s=6.
  - DOUBLE
  - MUL: repeat until (y+1) additions are done.
  - TRIPLE1
  - TRIPLE2
  - PLUS1
  - CMP: if not greater-or-equal, go to NEXT.
  - SUB1
  - SUB2: y+1.
  - NEXT: if s=0, go to DONE; otherwise s−3 and return to DOUBLE.
  - DONE: write result, clear busy, return to IDLE.
- Width rule: y ≤ 6, every intermediate value is below 2^16, and the adder never wraps in legal operation.
- `start` while busy is ignored. `x_i` changes after the latch cycle have no effect.
- `result` holds the previous root until DONE overwrites it.

## Timing
- Reset (asynchronous, active-low): `busy`=0, `result`=0, FSM to IDLE. Asserting reset mid-computation aborts it and no result is written.
- `start`=1 at edge N (state IDLE): `busy` is 1 after edge N, and `x_i` is latched at edge N.
- `busy` stays high continuously until the edge that writes `result`. From that edge on, `busy`=0 and `result` is valid.
- Latency is at most 60 cycles for any x. It depends on the data, through the MUL loop and the conditional subtract.
- A new `start` is accepted in the first cycle after `busy` falls.
- `start` held high continuously starts a new computation each time the unit returns to IDLE.

## Test plan
- Reset, then start with x=0, 1, 8, 27, 64, 125, 216 -> `busy` falls within 60 cycles with `result` = 0, 1, 2, 3, 4, 5, 6 respectively.
- Non-cubes 2, 5, 9, 17, 26, 28, 255 -> `result` = 1, 1, 2, 2, 2, 3, 6.
- Exhaustive sweep 0..255 against a floor-cube-root model, with a cycle counter -> every result matches and no run exceeds 60 cycles.
- Pulse `start` with x=27, and pulse `start` again with x=216 while busy -> second request is ignored and the result is 3. Changing `x_i` mid-run does not alter the result.
- Assert `rst` low in the middle of a run with x=125 -> `busy`=0 and `result`=0 immediately. A fresh start with x=64 then gives 4.
- Adder in isolation: a=0xFFFF, b=0x0002 -> 0x0001; a=300, b=45 -> 345.

Source files
------------

// File: rtl/cbrt_calc_if.sv
// Request/response bundle for the cube-root unit: start + operand in, root + busy out.
// No backpressure beyond busy; a start that arrives while busy is dropped.
interface cbrt_calc_if;
    logic       start;
    logic [7:0] x_i;
    logic [2:0] result;
    logic       busy;

    modport master (output start, output x_i, input result, input busy);
    modport slave  (input start, input x_i, output result, output busy);
endinterface

// File: rtl/cbrt_calc.sv
// Bit-serial 8-bit floor cube root over one shared 16-bit adder; 38 cycles worst case.
// Requests are accepted only in IDLE; start while busy is ignored and never queued.
module sum (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result
);
    assign result = a + b;
endmodule

module cbrt_calc (
    input  logic        clk,
    input  logic        rst,
    cbrt_calc_if.slave  io
);
    typedef enum logic [3:0] {
        IDLE, INIT, DOUBLE, MUL, TRIPLE1, TRIPLE2, PLUS1,
        CMP, SUB1, SUB2, NEXT, DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] x_rem, acc, bval, b_shift;
    logic [15:0] add_a, add_b, add_res;
    logic [2:0]  y, s, root;
    logic [7:0]  mul_oh;
    logic        ge;

    sum u_sum (.a(add_a), .b(add_b), .result(add_res));

    assign b_shift   = bval << s;
    assign ge        = (x_rem >= b_shift);
    assign io.result = root;
    assign io.busy   = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        add_a     = 16'd0;
        add_b     = 16'd0;
        case (state)
            IDLE:    if (io.start) state_nxt = INIT;
            INIT:    state_nxt = DOUBLE;
            DOUBLE: begin
                add_a     = {13'd0, y};
                add_b     = {13'd0, y};
                state_nxt = MUL;
            end
            // mul_oh marks how many adds have been issued; stop after y+1 of them
            MUL: begin
                add_a = acc;
                add_b = {13'd0, y};
                if (mul_oh[y]) state_nxt = TRIPLE1;
            end
            TRIPLE1: begin
                add_a     = acc;
                add_b     = acc;
                state_nxt = TRIPLE2;
            end
            TRIPLE2: begin
                add_a     = bval;
                add_b     = acc;
                state_nxt = PLUS1;
            end
            PLUS1: begin
                add_a     = bval;
                add_b     = 16'd1;
                state_nxt = CMP;
            end
            CMP:     state_nxt = ge ? SUB1 : NEXT;
            SUB1: begin
                add_a     = x_rem;
                add_b     = ~b_shift;
                state_nxt = SUB2;
            end
            SUB2: begin
                add_a     = x_rem;
                add_b     = 16'd1;
                state_nxt = NEXT;
            end
            NEXT:    state_nxt = (s == 3'd0) ? DONE : DOUBLE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_rem  <= 16'd0;
            acc    <= 16'd0;
            bval   <= 16'd0;
            y      <= 3'd0;
            s      <= 3'd0;
            root   <= 3'd0;
            mul_oh <= 8'd0;
        end else begin
            case (state)
                IDLE:    if (io.start) x_rem <= {8'd0, io.x_i};
                INIT: begin
                    y <= 3'd0;
                    s <= 3'd6;
                end
                DOUBLE: begin
                    y      <= add_res[2:0];
                    acc    <= 16'd0;
                    mul_oh <= 8'd1;
                end
                MUL: begin
                    acc    <= add_res;
                    mul_oh <= mul_oh << 1;
                end
                TRIPLE1, TRIPLE2, PLUS1: bval <= add_res;
                SUB1:    x_rem <= add_res;
                // y was just doubled so it is even: y+1 is setting bit 0
                SUB2: begin
                    x_rem <= add_res;
                    y     <= y | 3'd1;
                end
                NEXT:    if (s != 3'd0) s <= (s == 3'd6) ? 3'd3 : 3'd0;
                DONE:    root <= y;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cbrt_calc.sv
// Self-checking bench for cbrt_calc: vector table, exhaustive and random sweeps, corner sequences.
module tb_cbrt_calc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cbrt_calc_if io ();
    cbrt_calc dut (.clk(clk), .rst(rst), .io(io));

    logic [15:0] ta, tb, tr;
    sum u_add (.a(ta), .b(tb), .result(tr));

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [2:0] r;
    } vec_t;

    function automatic int cbrt_ref(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int cyc);
        checks++;
        if (cyc > 60) begin
            errors++;
            $display("FAIL %s: latency %0d cycles, limit 60", name, cyc);
        end
    endtask

    // Launch one request and wait (bounded) for busy to fall.
    task automatic run_one(input logic [7:0] x, input bit scramble,
                           output logic [2:0] r, output int cyc);
        @(negedge clk);
        io.start = 1'b1;
        io.x_i   = x;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        cyc = 1;
        chk("busy_rise", int'(io.busy), 1);
        if (scramble) io.x_i = ~x;
        while (io.busy === 1'b1 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        r = io.result;
    endtask

    vec_t        vecs[14];
    logic [2:0]  r;
    int          cyc;
    logic [7:0]  rx;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{8'd0,   3'd0};
        vecs[1]  = '{8'd1,   3'd1};
        vecs[2]  = '{8'd8,   3'd2};
        vecs[3]  = '{8'd27,  3'd3};
        vecs[4]  = '{8'd64,  3'd4};
        vecs[5]  = '{8'd125, 3'd5};
        vecs[6]  = '{8'd216, 3'd6};
        vecs[7]  = '{8'd2,   3'd1};
        vecs[8]  = '{8'd5,   3'd1};
        vecs[9]  = '{8'd9,   3'd2};
        vecs[10] = '{8'd17,  3'd2};
        vecs[11] = '{8'd26,  3'd2};
        vecs[12] = '{8'd28,  3'd3};
        vecs[13] = '{8'd255, 3'd6};

        io.start = 1'b0;
        io.x_i   = 8'd0;
        ta = 16'd0;
        tb = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(io.busy), 0);
        chk("reset_result", int'(io.result), 0);
        @(negedge clk);
        rst = 1'b1;

        // Adder in isolation
        ta = 16'hFFFF; tb = 16'h0002; #1;
        chk("adder_wrap", int'(tr), 16'h0001);
        ta = 16'd300; tb = 16'd45; #1;
        chk("adder_300_45", int'(tr), 345);
        for (int i = 0; i < 4; i++) begin
            ta = 16'($urandom); tb = 16'($urandom); #1;
            chk("adder_rand", int'(tr), int'((32'(ta) + 32'(tb)) & 32'hFFFF));
        end

        for (int i = 0; i < 14; i++) begin
            run_one(vecs[i].x, 1'b0, r, cyc);
            chk($sformatf("vec_x%0d", vecs[i].x), int'(r), int'(vecs[i].r));
            chk_lat($sformatf("vec_lat_x%0d", vecs[i].x), cyc);
        end

        for (int x = 0; x < 256; x++) begin
            run_one(8'(x), 1'b1, r, cyc);
            chk($sformatf("sweep_x%0d", x), int'(r), cbrt_ref(x));
            chk_lat($sformatf("sweep_lat_x%0d", x), cyc);
        end

        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom_range(0, 255));
            run_one(rx, 1'b1, r, cyc);
            chk($sformatf("rand_x%0d", rx), int'(r), cbrt_ref(int'(rx)));
        end

        // Second start while busy is dropped
        @(negedge clk);
        io.start = 1'b1; io.x_i = 8'd27;
        @(negedge clk);
        io.start = 1'b0; io.x_i = 8'd0;
        repeat (4) @(negedge clk);
        io.start = 1'b1; io.x_i = 8'd216;
        @(negedge clk);
        io.start = 1'b0; io.x_i = 8'd99;
        cyc = 0;
        while (io.busy === 1'b1 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        chk("busy_start_ignored", int'(io.result), 3);
        @(negedge clk);
        chk("idle_after_ignored", int'(io.busy), 0);

        // start held high restarts on every return to IDLE
        io.start = 1'b1; io.x_i = 8'd27;
        @(negedge clk);
        cyc = 0;
        while (io.busy === 1'b1 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_first_result", int'(io.result), 3);
        chk("held_idle_gap", int'(io.busy), 0);
        @(negedge clk);
        chk("held_restart_busy", int'(io.busy), 1);
        io.start = 1'b0; io.x_i = 8'd200;
        cyc = 0;
        while (io.busy === 1'b1 && cyc < 80) begin
            @(negedge clk);
            cyc++;
        end
        chk("held_second_result", int'(io.result), 3);

        // Reset mid-run aborts
        run_one(8'd216, 1'b0, r, cyc);
        chk("pre_abort_result", int'(r), 6);
        @(negedge clk);
        io.start = 1'b1; io.x_i = 8'd125;
        @(negedge clk);
        io.start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_busy", int'(io.busy), 0);
        chk("abort_result", int'(io.result), 0);
        @(negedge clk);
        rst = 1'b1;
        run_one(8'd64, 1'b0, r, cyc);
        chk("after_abort_x64", int'(r), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
